// File: rtl/booth_mul_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_sched_if
// Purpose  : Request/response bundle between requesters and the shared Booth
//            multiplier scheduler.
// Revision : 1.0
// ============================================================================
interface booth_mul_sched_if #(
    parameter int N   = 10,
    parameter int REQ = 4,
    parameter int IDW = $clog2(REQ)
);
    logic [REQ-1:0]   req_valid;
    logic [REQ*N-1:0] req_m;
    logic [REQ*N-1:0] req_q;
    logic [REQ-1:0]   req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [2*N-1:0]   rsp_p;
    logic             busy;

    modport master (
        output req_valid, req_m, req_q, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_p, busy
    );

    modport slave (
        input  req_valid, req_m, req_q, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_p, busy
    );
endinterface
`default_nettype wire

// File: rtl/booth_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : booth_mul_sched
// Purpose  : Round-robin scheduler sharing one radix-2 Booth sequential
//            multiplier among REQ requesters; tagged valid/ready response.
// Revision : 1.0
// ============================================================================
module booth_mul_sched #(
    parameter int N   = 10,
    parameter int REQ = 4,
    parameter int IDW = $clog2(REQ)
) (
    input  logic              clk,
    input  logic              rst,
    booth_mul_sched_if.slave  bus
);
    localparam int            CW     = $clog2(N + 1);
    localparam logic [IDW:0]  c_REQ  = (IDW + 1)'(REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic signed [N:0] r_a;
    logic signed [N:0] r_mr;
    logic [N-1:0]      r_q1;
    logic              r_q;
    logic [CW-1:0]     r_cnt;
    logic [IDW-1:0]    r_id;
    logic [IDW-1:0]    r_ptr;

    logic              w_found;
    logic [IDW-1:0]    w_gnt;
    logic [IDW:0]      w_cand;
    logic [IDW:0]      w_ptr_nxt;
    logic              w_take;
    logic              w_last;
    logic signed [N:0] w_a_op;
    logic [N-1:0]      w_m;
    logic [N-1:0]      w_q;

    // First valid requester searching from r_ptr upward, wrapping at REQ.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        for (int k = 0; k < REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IDW + 1)'(k);
            if (w_cand >= c_REQ)
                w_cand = w_cand - c_REQ;
            if (!w_found && bus.req_valid[w_cand[IDW-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_ptr_nxt = {1'b0, w_gnt} + (IDW + 1)'(1);
        if (w_ptr_nxt == c_REQ)
            w_ptr_nxt = '0;
    end

    assign w_m    = bus.req_m[int'(w_gnt)*N +: N];
    assign w_q    = bus.req_q[int'(w_gnt)*N +: N];
    assign w_take = (r_state == S_IDLE) && w_found;
    assign w_last = (r_cnt == CW'(N - 1));

    // Booth recoding of the current multiplier bit pair.
    always_comb begin
        case ({r_q1[0], r_q})
            2'b10:   w_a_op = r_a - r_mr;
            2'b01:   w_a_op = r_a + r_mr;
            default: w_a_op = r_a;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found)       w_state_nxt = S_ITER;
            S_ITER:  if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.rsp_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_mr  <= '0;
            r_q1  <= '0;
            r_q   <= 1'b0;
            r_cnt <= '0;
            r_id  <= '0;
            r_ptr <= '0;
        end else if (w_take) begin
            r_a   <= '0;
            r_mr  <= {w_m[N-1], w_m};
            r_q1  <= w_q;
            r_q   <= 1'b0;
            r_cnt <= '0;
            r_id  <= w_gnt;
            r_ptr <= w_ptr_nxt[IDW-1:0];
        end else if (r_state == S_ITER) begin
            // Add/sub result shifted right arithmetically across {A,Q1,q}.
            r_a   <= {w_a_op[N], w_a_op[N:1]};
            r_q1  <= {w_a_op[0], r_q1[N-1:1]};
            r_q   <= r_q1[0];
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Grant strobe is masked during reset so every output reads zero.
    always_comb begin
        bus.req_ready = '0;
        if (!rst && (r_state == S_IDLE) && w_found)
            bus.req_ready[w_gnt] = 1'b1;
        bus.rsp_valid = (r_state == S_DONE);
        bus.rsp_id    = (r_state == S_DONE) ? r_id : '0;
        bus.rsp_p     = (r_state == S_DONE) ? {r_a[N-1:0], r_q1} : '0;
        bus.busy      = (r_state != S_IDLE);
    end
endmodule
`default_nettype wire

// File: tb/tb_booth_mul_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_mul_sched
// Purpose  : Directed and random self-checking bench for booth_mul_sched.
// Revision : 1.0
// ============================================================================
module tb_booth_mul_sched;
    localparam int N   = 10;
    localparam int REQ = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    booth_mul_sched_if #(.N(N), .REQ(REQ), .IDW(IDW)) bus ();

    booth_mul_sched #(.N(N), .REQ(REQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int n_resp   = 0;

    task automatic set_op(input int r, input logic signed [N-1:0] m, input logic signed [N-1:0] q);
        bus.req_m[r*N +: N] = m;
        bus.req_q[r*N +: N] = q;
    endtask

    // Raise a lone request and return at the negedge after its accept edge.
    task automatic issue(input int r, input logic signed [N-1:0] m, input logic signed [N-1:0] q);
        int n;
        n = 0;
        set_op(r, m, q);
        bus.req_valid[r] = 1'b1;
        #1;
        while (bus.req_ready[r] !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (bus.req_ready[r] !== 1'b1) begin
            failures++;
            $display("FAIL issue_grant r=%0d req_ready=%b", r, bus.req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[r] = 1'b0;
    endtask

    // Wait for and complete one response handshake; returns at a negedge.
    task automatic wait_rsp(input bit rnd, output logic [IDW-1:0] id, output logic [2*N-1:0] p);
        int n;
        bit got;
        n = 0; got = 1'b0; id = '0; p = '0;
        while (!got && n < 300) begin
            @(negedge clk);
            if (rnd) bus.rsp_ready = 1'($urandom_range(0, 1));
            #1; n++;
            if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
                got = 1'b1; id = bus.rsp_id; p = bus.rsp_p;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL rsp_timeout rsp_valid=%b after %0d cycles", bus.rsp_valid, n);
        end else begin
            n_resp++;
            @(posedge clk);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
    endtask

    task automatic test_reset;
        bus.req_valid = '1;
        #12;
        checks++; if (bus.req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d want=0", bus.rsp_id); end
        checks++; if (bus.rsp_p !== 20'h0) begin failures++; $display("FAIL reset_rsp_p got=%h want=0", bus.rsp_p); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single;
        int i;
        @(negedge clk);
        set_op(2, 10'sd3, -10'sd7);
        bus.req_valid[2] = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b want=0100", bus.req_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        i = 1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin failures++; $display("FAIL single_iter req_ready=%b busy=%b want 0000/1", bus.req_ready, bus.busy); end
        while (bus.rsp_valid !== 1'b1 && i < 20) begin
            @(negedge clk); #1; i++;
        end
        checks++; if (i != 11) begin failures++; $display("FAIL single_latency got=%0d want=11", i); end
        checks++; if (bus.rsp_p !== 20'hFFFEB) begin failures++; $display("FAIL single_p got=%h want=FFFEB", bus.rsp_p); end
        checks++; if (bus.rsp_id !== 2'd2) begin failures++; $display("FAIL single_id got=%0d want=2", bus.rsp_id); end
        @(posedge clk);
        @(negedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL single_release rsp_valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy); end
    endtask

    task automatic test_corner;
        logic signed [N-1:0] cm [4];
        logic signed [N-1:0] cq [4];
        logic [2*N-1:0]      ce [4];
        logic [IDW-1:0]      id;
        logic [2*N-1:0]      p;
        cm[0] = -10'sd512; cq[0] = -10'sd512; ce[0] = 20'h40000;
        cm[1] =  10'sd511; cq[1] = -10'sd512; ce[1] = 20'hC0200;
        cm[2] =  10'sd0;   cq[2] = -10'sd1;   ce[2] = 20'h00000;
        cm[3] = -10'sd1;   cq[3] = -10'sd1;   ce[3] = 20'h00001;
        for (int k = 0; k < 4; k++) begin
            issue(k, cm[k], cq[k]);
            wait_rsp(1'b0, id, p);
            checks++; if (p !== ce[k]) begin failures++; $display("FAIL corner%0d_p got=%h want=%h", k, p, ce[k]); end
            checks++; if (id !== IDW'(k)) begin failures++; $display("FAIL corner%0d_id got=%0d want=%0d", k, id, k); end
        end
    endtask

    task automatic test_round_robin;
        int             eg [5];
        logic [2*N-1:0] ep [5];
        logic [IDW-1:0] id;
        logic [2*N-1:0] p;
        int             g;
        int             n;
        eg[0] = 0; ep[0] = 20'd30;
        eg[1] = 1; ep[1] = 20'hFFFC8;
        eg[2] = 2; ep[2] = 20'hFFED4;
        eg[3] = 3; ep[3] = 20'hC0200;
        eg[4] = 0; ep[4] = 20'd81;
        @(negedge clk);
        set_op(0, 10'sd5, 10'sd6);
        set_op(1, -10'sd7, 10'sd8);
        set_op(2, 10'sd100, -10'sd3);
        set_op(3, -10'sd512, 10'sd511);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            #1;
            while (bus.req_ready === 4'b0000 && n < 50) begin
                @(negedge clk); #1; n++;
            end
            g = -1;
            for (int b = 0; b < REQ; b++)
                if (bus.req_ready[b] === 1'b1 && g < 0) g = b;
            checks++;
            if (g != eg[k] || !$onehot(bus.req_ready)) begin
                failures++; $display("FAIL rr_grant%0d req_ready=%b want grant %0d", k, bus.req_ready, eg[k]);
            end
            @(posedge clk);
            @(negedge clk);
            if (g >= 0) bus.req_valid[g] = 1'b0;
            if (k == 0) begin
                set_op(0, -10'sd9, -10'sd9);
                bus.req_valid[0] = 1'b1;
            end
            wait_rsp(1'b0, id, p);
            checks++; if (id !== IDW'(eg[k]) || p !== ep[k]) begin failures++; $display("FAIL rr_rsp%0d id=%0d p=%h want id=%0d p=%h", k, id, p, eg[k], ep[k]); end
        end
    endtask

    task automatic test_backpressure;
        logic [IDW-1:0] id;
        logic [2*N-1:0] p;
        int             n;
        bus.rsp_ready = 1'b0;
        issue(2, 10'sd13, -10'sd11);
        set_op(1, 10'sd7, 10'sd7);
        bus.req_valid[1] = 1'b1;
        n = 0;
        #1;
        while (bus.rsp_valid !== 1'b1 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_p !== 20'hFFF71 || bus.rsp_id !== 2'd2 ||
                bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold%0d valid=%b p=%h id=%0d req_ready=%b busy=%b want 1/FFF71/2/0000/1",
                         c, bus.rsp_valid, bus.rsp_p, bus.rsp_id, bus.req_ready, bus.busy);
            end
            @(negedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release rsp_valid=%b req_ready=%b want 0/0010", bus.rsp_valid, bus.req_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        wait_rsp(1'b0, id, p);
        checks++; if (id !== 2'd1 || p !== 20'd49) begin failures++; $display("FAIL bp_next id=%0d p=%h want id=1 p=00031", id, p); end
    endtask

    task automatic test_reset_mid;
        logic [IDW-1:0] id;
        logic [2*N-1:0] p;
        bit             stale;
        int             n;
        issue(1, 10'sd100, 10'sd100);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000 || bus.rsp_valid !== 1'b0 || bus.rsp_id !== 2'd0 ||
            bus.rsp_p !== 20'h0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_async req_ready=%b valid=%b id=%0d p=%h busy=%b want all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_p, bus.busy);
        end
        @(negedge clk);
        rst = 1'b0;
        stale = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk); #1;
            if (bus.rsp_valid !== 1'b0) stale = 1'b1;
        end
        checks++; if (stale) begin failures++; $display("FAIL rst_stale rsp_valid seen=1 want 0"); end
        set_op(3, 10'sd21, -10'sd2);
        set_op(1, -10'sd5, -10'sd5);
        bus.req_valid = 4'b1010;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin failures++; $display("FAIL rst_ptr req_ready=%b want 0010", bus.req_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        wait_rsp(1'b0, id, p);
        checks++; if (id !== 2'd1 || p !== 20'd25) begin failures++; $display("FAIL rst_rsp1 id=%0d p=%h want id=1 p=00019", id, p); end
        n = 0;
        #1;
        while (bus.req_ready !== 4'b1000 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++; if (bus.req_ready !== 4'b1000) begin failures++; $display("FAIL rst_grant3 req_ready=%b want 1000", bus.req_ready); end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        wait_rsp(1'b0, id, p);
        checks++; if (id !== 2'd3 || p !== 20'hFFFD6) begin failures++; $display("FAIL rst_rsp3 id=%0d p=%h want id=3 p=FFFD6", id, p); end
    endtask

    task automatic test_random;
        logic signed [N-1:0]   m;
        logic signed [N-1:0]   q;
        logic signed [2*N-1:0] e;
        logic [IDW-1:0]        id;
        logic [2*N-1:0]        p;
        int                    r;
        int                    base;
        base = n_resp;
        for (int t = 0; t < 2000; t++) begin
            r = int'($urandom_range(0, REQ - 1));
            m = N'($urandom);
            q = N'($urandom);
            e = m * q;
            issue(r, m, q);
            wait_rsp(1'b1, id, p);
            checks++;
            if (p !== e || id !== IDW'(r)) begin
                failures++;
                $display("FAIL rand%0d m=%0d q=%0d id=%0d p=%h want id=%0d p=%h", t, m, q, id, p, r, e);
            end
            #1;
            checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rand%0d_dup rsp_valid=%b want 0", t, bus.rsp_valid); end
        end
        checks++; if (n_resp - base != 2000) begin failures++; $display("FAIL rand_count got=%0d want=2000", n_resp - base); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_m     = '0;
        bus.req_q     = '0;
        bus.rsp_ready = 1'b1;
        #1 rst = 1'b1;
        test_reset();
        test_single();
        test_corner();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/booth_mul_sched.md
Name: booth_mul_sched

Overview:
Shares one sequential radix-2 Booth multiply engine among REQ requesters.
- Arbitrates incoming multiply requests round-robin.
- Sequences the Booth add/sub-and-shift datapath one step per clock.
- Returns the signed product tagged with the requester index over a valid/ready response channel.
- Sits between DSP-side requesters and the arithmetic core, replacing per-requester multipliers.

Parameters:
- N, 10, signed operand width (N >= 2).
- REQ, 4, number of requesters (REQ >= 2).
- IDW, $clog2(REQ), width of requester index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  REQ  per-requester request valid.
- req_m  in  REQ*N  multiplicands, requester i at bits [i*N +: N], signed.
- req_q  in  REQ*N  multipliers, same packing, signed.
- req_ready  out  REQ  one-hot accept strobe; at most one bit high.
- rsp_valid  out  1  product available.
- rsp_ready  in  1  consumer accepts product.
- rsp_id  out  IDW  index of requester that owns rsp_p.
- rsp_p  out  2*N  signed product M*Q.
- busy  out  1  high whenever state != IDLE.

Behaviour:
Reset (async, rst=1):
- State IDLE, rr pointer = 0, step counter = 0, internal registers = 0.
- Outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_p=0, busy=0.
- Reset asserted mid-operation aborts the job silently; no response is ever produced for it.

Internal registers:
- A: N+1 bits signed. The guard bit makes M = -2^(N-1) exact.
- Mr: N+1, sign-extended M.
- Q1: N bits.
- q: 1 bit.
- cnt: $clog2(N+1) bits.
- id: IDW bits.
- ptr: IDW bits.

State machine, states IDLE, ITER, DONE:
- IDLE:
  - req_ready is combinational: bit g is high, where g is the first index with req_valid set, searching ptr, ptr+1, … wrapping modulo REQ.
  - A transfer occurs when req_valid[g] && req_ready[g].
  - On transfer (clock edge): A=0, Mr=sext(req_m[g]), Q1=req_q[g], q=0, cnt=0, id=g, ptr=(g+1) mod REQ, go to ITER.
  - No valid requests: stay in IDLE, ptr unchanged.
- ITER (one Booth step per cycle):
  - {Q1[0],q}=10: A=A-Mr.
  - {Q1[0],q}=01: A=A+Mr.
  - Otherwise A is unchanged.
  - Then arithmetic right shift of {A,Q1,q} by 1, with the sign bit of A replicated. Add/sub and shift happen in the same cycle.
  - cnt increments; after the N-th step go to DONE.
- DONE:
  - rsp_valid=1, rsp_p={A,Q1}[2N-1:0], rsp_id=id.
  - Response is held stable while rsp_ready=0.
  - On rsp_valid && rsp_ready: go to IDLE, deassert rsp_valid.
- req_ready is 0 in ITER and DONE. No request is accepted until the response handshake completes, so the engine holds one job at a time.
- Latency: acceptance edge at cycle T → rsp_valid high from cycle T+N+1. Throughput is one product per N+2 cycles with rsp_ready tied high.
- Simultaneous requests: exactly one is granted; the others wait, keeping valid and operands stable.
- A requester may drop req_valid before grant with no effect.
- Grant fairness: with all REQ requesting continuously, grants cycle 0,1,…,REQ-1,0.
- rsp_p and rsp_id are registered, with no combinational path from req_* to rsp_*.
- Arithmetic is exact for all operand pairs, including -2^(N-1) × -2^(N-1) = 2^(2N-2).

Test Plan:
- Single request, N=10: requester 2 sends M=3, Q=-7, rsp_ready=1 → req_ready=4'b0100 for one cycle; rsp_valid exactly 11 cycles after the accept edge; rsp_p=-21 (20'hFFFEB), rsp_id=2.
- Corner operands:
  - M=-512, Q=-512 → rsp_p=262144.
  - M=511, Q=-512 → -261632.
  - M=0, Q=-1 → 0.
  - M=-1, Q=-1 → 1.
- Round-robin: all four requesters valid from the same cycle with distinct operands → grant order 0,1,2,3. Requester 0 re-requesting immediately is served next only after 1,2,3. Each rsp_id matches its product.
- Backpressure: hold rsp_ready=0 for 5 cycles in DONE → rsp_valid, rsp_p, rsp_id stay constant; req_ready stays 0; busy=1. Releasing rsp_ready → return to IDLE next cycle, next grant follows.
- Reset mid-ITER: assert rst 4 cycles after accept → all outputs 0 immediately (asynchronously). After release, no stale response appears; a new request from requester 3 is granted first only if requesters 0–2 are idle (ptr reset to 0).
- Random regression: 2000 random operand pairs across random requesters with random rsp_ready → every rsp_p equals the exact signed product; each request is answered exactly once with the correct rsp_id.
